seq_divider16: RTL

- Sequential unsigned restoring divider; the inverse-direction counterpart of the fp16 multiplier datapath.
- Used for mantissa/integer division in the fp16 path.
- Takes WIDTH-bit dividend and divisor on a start/busy/done handshake.
- Produces quotient and remainder after WIDTH iteration cycles, one trial subtraction per cycle.

---
 rtl/seq_divider16.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider16.sv
// Sequential unsigned restoring divider: one trial subtraction per clock, start/busy/done handshake.
// Optional SIGNED_DIV_EN macro: two's-complement operands with a FIXUP sign-correction state.
module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int XW = WIDTH + 2;

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   partial_q, partial_d;
    logic [WIDTH-1:0] shift_q, shift_d;     // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
`endif

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             carry;
    logic [WIDTH:0]   step_partial;
    logic [WIDTH-1:0] step_shift;
    logic             last_step;

`ifdef SIGNED_DIV_EN
    assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    // Trial subtraction as an add of the inverted divisor with carry-in; carry-out set means no borrow.
    assign shifted = {partial_q[WIDTH-1:0], shift_q[WIDTH-1]};
    assign {carry, trial} = {1'b0, shifted} + {2'b01, ~divisor_q} + XW'(1);

    assign step_partial = carry ? trial : shifted;
    assign step_shift   = {shift_q[WIDTH-2:0], carry};
    assign last_step    = (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        partial_d   = partial_q;
        shift_d     = shift_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        shift_d   = dvd_mag;
                        divisor_d = dvs_mag;
                        partial_d = '0;
                        count_d   = '0;
`ifdef SIGNED_DIV_EN
                        neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d = dividend[WIDTH-1];
`endif
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                partial_d = step_partial;
                shift_d   = step_shift;
                count_d   = count_q + 1'b1;
                if (last_step) begin
`ifdef SIGNED_DIV_EN
                    state_d     = FIXUP;
`else
                    quotient_d  = step_shift;
                    remainder_d = step_partial[WIDTH-1:0];
                    state_d     = DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            FIXUP: begin
                quotient_d  = neg_quo_q ? (~shift_q + 1'b1) : shift_q;
                remainder_d = neg_rem_q ? (~partial_q[WIDTH-1:0] + 1'b1) : partial_q[WIDTH-1:0];
                state_d     = DONE;
            end
`endif
            DONE: begin
                dbz_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            partial_q   <= '0;
            shift_q     <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            partial_q   <= partial_d;
            shift_q     <= shift_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SIGNED_DIV_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    // The partial remainder always stays below the divisor, so its extra top bit never sets.
    assert property (@(posedge clk) disable iff (rst) (partial_q[WIDTH] == 1'b0));

`ifdef SIGNED_DIV_EN
    assign busy = (state_q == RUN) || (state_q == FIXUP);
`else
    assign busy = (state_q == RUN);
`endif
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
